// File: rtl/mem_b_write_ctrl_if.sv
// mem_b_write_ctrl_if: source handshake and memory B write bus
// for the destination side of the mem-to-mem transfer path.
interface mem_b_write_ctrl_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          start;
  logic [AW:0]   len;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic [DW-1:0] chk;

  modport master (
    output start,
    output len,
    output in_data,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  busy,
    input  done,
    input  count,
    input  chk
  );

  modport slave (
    input  start,
    input  len,
    input  in_data,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output busy,
    output done,
    output count,
    output chk
  );
endinterface

// File: rtl/mem_b_write_ctrl.sv
// mem_b_write_ctrl: memory B write strobes for the mem-to-mem path.
// Optional XOR checksum of written words under MEMB_CHECKSUM_EN.
module mem_b_write_ctrl #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input logic                   clk,
  input logic                   rst,
  mem_b_write_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  state_t        r_state;
  state_t        w_next;
  logic          w_ready;
  logic          w_busy;
  logic          w_done;
  logic          w_start;
  logic          w_accept;
  logic          w_last;
  logic [AW:0]   r_limit;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_addr;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;

  assign w_start  = (r_state == S_IDLE) && bus.start;
  assign w_accept = w_ready && bus.in_valid;
  assign w_last   = (r_count + 1'b1) == r_limit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_XFER;
      S_XFER: if (w_accept && w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_XFER: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes lag the accept by one cycle; count tracks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_limit   <= '0;
      r_count   <= '0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_start) begin
        r_limit <= (bus.len == '0) ? DEPTH : bus.len;
        r_count <= '0;
        r_addr  <= '0;
      end else if (w_accept) begin
        r_wr_addr <= r_addr;
        r_wr_data <= bus.in_data;
        r_addr    <= r_addr + 1'b1;
        r_count   <= r_count + 1'b1;
      end
    end
  end

`ifdef MEMB_CHECKSUM_EN
  logic [DW-1:0] r_chk;

  always_ff @(posedge clk) begin
    if (rst)           r_chk <= '0;
    else if (w_start)  r_chk <= '0;
    else if (w_accept) r_chk <= r_chk ^ bus.in_data;
  end

  assign bus.chk = r_chk;
`else
  assign bus.chk = '0;
`endif

  assign bus.in_ready = w_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.count    = r_count;

endmodule

// File: tb/tb_mem_b_write_ctrl.sv
// tb_mem_b_write_ctrl: directed plus random stimulus against a
// transfer-level reference model of mem_b_write_ctrl.
module tb_mem_b_write_ctrl;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_b_write_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mem_b_write_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: transfer-level bookkeeping
  bit          m_xfer;
  bit          m_done;
  int          m_limit;
  int          m_count;
  logic [7:0]  m_chk;
  bit          e_wr_en;
  int          e_addr;
  logic [7:0]  e_data;
  bit          e_bus_chk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_chk();
`ifdef MEMB_CHECKSUM_EN
    return m_chk;
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_edge(input bit r, input bit s,
                            input int l, input bit v,
                            input logic [7:0] d);
    e_wr_en   = 0;
    e_bus_chk = 0;
    if (r) begin
      m_xfer = 0; m_done = 0; m_count = 0;
      m_limit = 0; m_chk = 0;
      e_addr = 0; e_data = 0; e_bus_chk = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_xfer) begin
      if (v) begin
        e_wr_en   = 1;
        e_bus_chk = 1;
        e_addr    = m_count % DEPTH;
        e_data    = d;
        m_count++;
        m_chk ^= d;
        if (m_count == m_limit) begin
          m_xfer = 0;
          m_done = 1;
        end
      end
    end else if (s) begin
      m_xfer  = 1;
      m_limit = (l == 0) ? DEPTH : l;
      m_count = 0;
      m_chk   = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input int l,
                      input bit v, input logic [7:0] d);
    rst          = r;
    bus.start    = s;
    bus.len      = l[AW:0];
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    model_edge(r, s, l, v, d);
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(m_xfer));
    check("busy", 32'(bus.busy), 32'(m_xfer | m_done));
    check("done", 32'(bus.done), 32'(m_done));
    check("wr_en", 32'(bus.wr_en), 32'(e_wr_en));
    check("count", 32'(bus.count), 32'(m_count));
    check("chk", 32'(bus.chk), 32'(exp_chk()));
    if (e_bus_chk) begin
      check("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
      check("wr_data", 32'(bus.wr_data), 32'(e_data));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    bit          v;
    bit          s;
    bit          r;
    logic [7:0]  cc;
    bit          pat [6];

    bus.start = 0; bus.len = '0;
    bus.in_valid = 0; bus.in_data = '0;
    m_xfer = 0; m_done = 0; m_count = 0;
    m_limit = 0; m_chk = 0;
    e_addr = 0; e_data = 0;

    // reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), int'($urandom_range(0, 15)),
           1'($urandom), 8'($urandom));
    idle(1);

    // basic len=3
    step(0, 1, 3, 0, 8'h00);
    step(0, 0, 0, 1, 8'hA1);
    step(0, 0, 0, 1, 8'hB2);
    step(0, 0, 0, 1, 8'hC3);
    check("basic_count", 32'(bus.count), 32'd3);
    check("basic_done", 32'(bus.done), 32'd1);
    idle(2);

    // bubbles plus ignored start
    pat = '{1, 0, 1, 1, 0, 1};
    step(0, 1, 4, 0, 8'h00);
    for (int i = 0; i < 6; i++)
      step(0, (i == 2), 7, pat[i], 8'($urandom));
    check("bub_count", 32'(bus.count), 32'd4);
    check("bub_addr", 32'(bus.wr_addr), 32'd3);
    idle(2);

    // full depth, then len=1 right after DONE
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, 0, 1, 8'(i * 17 + 3));
    check("full_addr", 32'(bus.wr_addr), 32'd7);
    check("full_count", 32'(bus.count), 32'd8);
    step(0, 1, 2, 1, 8'h55);
    step(0, 1, 1, 0, 8'h00);
    step(0, 0, 0, 1, 8'h66);
    check("len1_addr", 32'(bus.wr_addr), 32'd0);
    idle(2);

    // reset mid-transfer
    step(0, 1, 5, 0, 8'h00);
    step(0, 0, 0, 1, 8'h11);
    step(0, 0, 0, 1, 8'h22);
    step(1, 1, 3, 1, 8'h33);
    check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    step(0, 1, 2, 0, 8'h00);
    step(0, 0, 0, 1, 8'h44);
    step(0, 0, 0, 1, 8'h45);
    idle(2);

    // checksum
    step(0, 1, 3, 0, 8'h00);
    step(0, 0, 0, 1, 8'h0F);
    step(0, 0, 0, 1, 8'hF0);
    step(0, 0, 0, 1, 8'h33);
`ifdef MEMB_CHECKSUM_EN
    cc = 8'hCC;
`else
    cc = 8'h00;
`endif
    check("chk_done", 32'(bus.chk), 32'(cc));
    idle(2);

    // random
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 63) == 0);
      s = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 9) < 7);
      step(r, s, int'($urandom_range(0, 15)), v, 8'($urandom));
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
